multi_phase_pwm: RTL and testbench



---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_deadtime_gen.sv | 42 ++++
 rtl/multi_phase_pwm.sv | 174 +++++++++++++++++
 tb/tb_multi_phase_pwm.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-phase PWM generator: default widths and
// the counting-mode and counting-direction encodings.
`timescale 1ns/1ps
package pwm_pkg;

    localparam int N_CH_DEF  = 3;
    localparam int CNT_W_DEF = 16;
    localparam int DT_W_DEF  = 8;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

endpackage

// File: rtl/pwm_deadtime_gen.sv
// Complementary dead-time generator for one channel: Hs follows Raw and Ls
// follows ~Raw, each delayed by Dead_Time_i cycles on its rising edge only.
`timescale 1ns/1ps
module pwm_deadtime_gen
    import pwm_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            Clr_i,
    input  logic            Raw_i,
    input  logic [DT_W-1:0] Dead_Time_i,
    output logic            Hs_o,
    output logic            Ls_o
);

    logic            prev_q;
    logic [DT_W-1:0] run_q;
    logic [DT_W-1:0] run_now;
    logic [DT_W-1:0] run_d;

    // run_now is the number of cycles Raw has already held its current level;
    // it saturates, which is safe because Dead_Time_i never exceeds all-ones.
    always_comb begin
        run_now = (Raw_i != prev_q) ? '0 : run_q;
        run_d   = (run_now == '1) ? run_now : run_now + 1'b1;
        Hs_o    = !Clr_i &&  Raw_i && (run_now >= Dead_Time_i);
        Ls_o    = !Clr_i && !Raw_i && (run_now >= Dead_Time_i);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n || Clr_i) begin
            prev_q <= 1'b0;
            run_q  <= '0;
        end else begin
            prev_q <= Raw_i;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/multi_phase_pwm.sv
// N-channel complementary PWM with a shared edge/centre-aligned timebase,
// shadowed period/duty/dead time and a sticky period interrupt.
// Optional fault input path is enabled by defining PWM_FAULT_EN.
`timescale 1ns/1ps
module multi_phase_pwm
    import pwm_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int DT_W  = DT_W_DEF
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Enable,
    input  logic                  Center_Mode,
    input  logic [CNT_W-1:0]      Period,
    input  logic [N_CH*CNT_W-1:0] Duty,
    input  logic [DT_W-1:0]       Dead_Time,
    input  logic                  Update_Req,
    output logic                  Update_Ack,
    output logic [N_CH-1:0]       Pwm_Hs,
    output logic [N_CH-1:0]       Pwm_Ls,
    input  logic                  Irq_Enable,
    input  logic                  Irq_Clear,
`ifdef PWM_FAULT_EN
    input  logic                  Fault_n,
    input  logic                  Fault_Clr,
    output logic                  Fault_Latched,
`endif
    output logic                  Irq_Status
);

    function automatic logic [CNT_W-1:0] clamp_duty(input logic [CNT_W-1:0] d,
                                                    input logic [CNT_W-1:0] p);
        return (d > p) ? p : d;
    endfunction

    logic [CNT_W-1:0]      count_q, count_d;
    pwm_dir_e              dir_q, dir_d;
    pwm_mode_e             mode_q;
    logic                  start_q;
    logic [CNT_W-1:0]      per_q;
    logic [N_CH*CNT_W-1:0] duty_q;
    logic [DT_W-1:0]       dt_q;
    logic                  pending_q;
    logic                  ack_q;
    logic                  irq_q;
    logic                  run_q;
    logic [N_CH-1:0]       raw_q, raw_d;
    logic                  boundary;
    logic                  take;
    logic                  per_small;
    logic [CNT_W-1:0]      per_last;
    logic                  gate_off;

    assign per_small = (per_q[CNT_W-1:1] == '0);
    assign per_last  = per_q - 1'b1;

    // The first enabled cycle after a stop is a boundary of its own, so the
    // shadows and mode can be loaded before the first real period starts.
    always_comb begin
        count_d  = count_q;
        dir_d    = dir_q;
        boundary = 1'b0;
        if (!Enable) begin
            count_d = '0;
            dir_d   = DIR_UP;
        end else if (start_q || per_small) begin
            boundary = 1'b1;
            count_d  = '0;
            dir_d    = DIR_UP;
        end else if (mode_q == PWM_EDGE) begin
            if (count_q == per_last) begin
                boundary = 1'b1;
                count_d  = '0;
                dir_d    = DIR_UP;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (dir_q == DIR_UP) begin
            if (count_q == per_last) dir_d = DIR_DOWN;
            else                     count_d = count_q + 1'b1;
        end else begin
            if (count_q == '0) begin
                boundary = 1'b1;
                dir_d    = DIR_UP;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_comb begin
        raw_d = '0;
        for (int k = 0; k < N_CH; k++) begin
            raw_d[k] = Enable && !start_q && !per_small &&
                       (count_q < clamp_duty(duty_q[k*CNT_W +: CNT_W], per_q));
        end
    end

    assign take = boundary && (pending_q || Update_Req);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            count_q   <= '0;
            dir_q     <= DIR_UP;
            mode_q    <= PWM_EDGE;
            start_q   <= 1'b1;
            per_q     <= '0;
            duty_q    <= '0;
            dt_q      <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            irq_q     <= 1'b0;
            run_q     <= 1'b0;
            raw_q     <= '0;
        end else begin
            count_q   <= count_d;
            dir_q     <= dir_d;
            start_q   <= !Enable;
            run_q     <= Enable;
            raw_q     <= raw_d;
            ack_q     <= take;
            pending_q <= take ? 1'b0 : (pending_q || Update_Req);
            if (boundary) mode_q <= pwm_mode_e'(Center_Mode);
            if (take) begin
                per_q  <= Period;
                duty_q <= Duty;
                dt_q   <= Dead_Time;
            end
            if (boundary && Irq_Enable) irq_q <= 1'b1;
            else if (Irq_Clear)         irq_q <= 1'b0;
        end
    end

`ifdef PWM_FAULT_EN
    logic fault_q;
    logic blk_q;

    // Outputs stay blocked until the latch is cleared and a boundary passes.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            fault_q <= 1'b0;
            blk_q   <= 1'b0;
        end else begin
            if (!Fault_n)       fault_q <= 1'b1;
            else if (Fault_Clr) fault_q <= 1'b0;
            if (!Fault_n)                  blk_q <= 1'b1;
            else if (boundary && !fault_q) blk_q <= 1'b0;
        end
    end

    assign Fault_Latched = fault_q;
    assign gate_off      = !run_q || blk_q;
`else
    assign gate_off = !run_q;
`endif

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        pwm_deadtime_gen #(.DT_W(DT_W)) u_dt (
            .Clk         (Clk),
            .Reset_n     (Reset_n),
            .Clr_i       (gate_off),
            .Raw_i       (raw_q[k]),
            .Dead_Time_i (dt_q),
            .Hs_o        (Pwm_Hs[k]),
            .Ls_o        (Pwm_Ls[k])
        );
    end

    assign Update_Ack = ack_q;
    assign Irq_Status = irq_q;

endmodule

// File: tb/tb_multi_phase_pwm.sv
// Self-checking bench for multi_phase_pwm: table-driven duty vectors,
// hand-written update/irq/reset sequences and a randomized run against a model.
`timescale 1ns/1ps
module tb_multi_phase_pwm;
    localparam int N_CH  = 3;
    localparam int CNT_W = 16;
    localparam int DT_W  = 8;
    localparam int HN    = 512;

    logic                  Clk = 1'b0;
    logic                  Reset_n, Enable, Center_Mode, Update_Req;
    logic                  Irq_Enable, Irq_Clear;
    logic [CNT_W-1:0]      Period;
    logic [N_CH*CNT_W-1:0] Duty;
    logic [DT_W-1:0]       Dead_Time;
    logic                  Update_Ack, Irq_Status;
    logic [N_CH-1:0]       Pwm_Hs, Pwm_Ls;
`ifdef PWM_FAULT_EN
    logic Fault_n = 1'b1, Fault_Clr = 1'b0, Fault_Latched;
`endif

    always #5 Clk = ~Clk;

    multi_phase_pwm #(.N_CH(N_CH), .CNT_W(CNT_W), .DT_W(DT_W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Enable(Enable), .Center_Mode(Center_Mode),
        .Period(Period), .Duty(Duty), .Dead_Time(Dead_Time),
        .Update_Req(Update_Req), .Update_Ack(Update_Ack),
        .Pwm_Hs(Pwm_Hs), .Pwm_Ls(Pwm_Ls),
        .Irq_Enable(Irq_Enable), .Irq_Clear(Irq_Clear),
`ifdef PWM_FAULT_EN
        .Fault_n(Fault_n), .Fault_Clr(Fault_Clr), .Fault_Latched(Fault_Latched),
`endif
        .Irq_Status(Irq_Status)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ncyc     = 0;

    // Reference model: position within the PWM period plus a raw history per channel.
    int  m_pos, m_P, m_DT;
    int  m_D [N_CH];
    bit  m_start, m_mode, m_pend, m_ack, m_irq, m_run;
    bit  m_raw [N_CH];
    bit  hist [N_CH][HN];
    int  hn;
    logic [N_CH-1:0] ehs, els;

    typedef struct {
        bit mode; int P; int d0; int d1; int d2; int dt;
        int len; int hs0; int ls0; int hs1; int hs2;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    function automatic int run_len(int k);
        int L;
        bit v;
        v = hist[k][(hn-1) % HN];
        L = 1;
        while (L < hn && L < 300 && hist[k][(hn-1-L) % HN] == v) L++;
        return L;
    endfunction

    task automatic model_update();
        int len, cnt, eff;
        bit bnd, take;
        bit nraw [N_CH];
        if (!Reset_n) begin
            m_pos = 0; m_start = 1; m_mode = 0; m_P = 0; m_DT = 0;
            m_pend = 0; m_ack = 0; m_irq = 0; m_run = 0;
            for (int k = 0; k < N_CH; k++) begin m_D[k] = 0; m_raw[k] = 0; end
        end else begin
            len = m_mode ? 2*m_P : m_P;
            bnd = Enable && (m_start || m_P < 2 || m_pos == len-1);
            cnt = (!m_mode || m_pos < m_P) ? m_pos : 2*m_P-1-m_pos;
            for (int k = 0; k < N_CH; k++) begin
                eff = (m_D[k] > m_P) ? m_P : m_D[k];
                nraw[k] = Enable && !m_start && m_P >= 2 && cnt < eff;
            end
            take    = bnd && (m_pend || Update_Req);
            m_pos   = (!Enable || bnd) ? 0 : m_pos + 1;
            m_start = !Enable;
            if (bnd) m_mode = Center_Mode;
            if (take) begin
                m_P  = int'(Period);
                m_DT = int'(Dead_Time);
                for (int k = 0; k < N_CH; k++) m_D[k] = int'(Duty[k*CNT_W +: CNT_W]);
            end
            m_pend = take ? 1'b0 : (m_pend || Update_Req);
            m_ack  = take;
            if (bnd && Irq_Enable) m_irq = 1;
            else if (Irq_Clear)    m_irq = 0;
            m_run = Enable;
            for (int k = 0; k < N_CH; k++) m_raw[k] = nraw[k];
        end
        if (m_run) begin
            for (int k = 0; k < N_CH; k++) hist[k][hn % HN] = m_raw[k];
            hn++;
        end else begin
            hn = 0;
        end
        for (int k = 0; k < N_CH; k++) begin
            ehs[k] = m_run && (m_raw[k]  && run_len(k) > m_DT);
            els[k] = m_run && (!m_raw[k] && run_len(k) > m_DT);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_update();
        #1;
        ncyc++;
        chk("hs", 32'(Pwm_Hs), 32'(ehs));
        chk("ls", 32'(Pwm_Ls), 32'(els));
        chk("ack", 32'(Update_Ack), 32'(m_ack));
        chk("irq", 32'(Irq_Status), 32'(m_irq));
        chk("overlap", 32'(Pwm_Hs & Pwm_Ls), 32'd0);
    endtask

    task automatic set_shadow(input bit mode, input int P, input int d0, input int d1,
                              input int d2, input int dt);
        Center_Mode = mode;
        Period      = CNT_W'(P);
        Duty        = {CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
        Dead_Time   = DT_W'(dt);
    endtask

    task automatic apply_cfg(input bit mode, input int P, input int d0, input int d1,
                             input int d2, input int dt);
        int w;
        set_shadow(mode, P, d0, d1, d2, dt);
        Update_Req = 1;
        tick();
        Update_Req = 0;
        w = 0;
        while (!Update_Ack && w < 100) begin tick(); w++; end
        chk("ack_timeout", 32'(Update_Ack), 32'd1);
    endtask

    initial begin
        int hs0, ls0, hs1, hs2, w, hs_between, irq_cnt;
        vecs[0] = '{0, 10, 3, 0, 20, 0, 10, 3, 7, 0, 10};
        vecs[1] = '{1,  8, 2, 0, 20, 1, 16, 3, 11, 0, 16};
        vecs[2] = '{0, 10, 3, 0, 20, 5, 10, 0, 2, 0, 10};
        vecs[3] = '{0, 10, 7, 10, 5, 2, 10, 5, 1, 10, 3};
        vecs[4] = '{1,  5, 1, 4, 0, 0, 10, 2, 8, 8, 0};
        vecs[5] = '{1,  6, 3, 5, 6, 3, 12, 3, 3, 7, 12};
        vecs[6] = '{0,  2, 1, 2, 0, 0, 2, 1, 1, 2, 0};

        Reset_n = 0; Enable = 0; Update_Req = 0; Irq_Enable = 0; Irq_Clear = 0;
        set_shadow(0, 0, 0, 0, 0, 0);
        hn = 0;
        repeat (3) tick();
        chk("rst_hs", 32'(Pwm_Hs), 32'd0);
        chk("rst_ls", 32'(Pwm_Ls), 32'd0);
        chk("rst_ack", 32'(Update_Ack), 32'd0);
        chk("rst_irq", 32'(Irq_Status), 32'd0);

        Reset_n = 1; Enable = 1; Irq_Enable = 1;
        for (int v = 0; v < 7; v++) begin
            apply_cfg(vecs[v].mode, vecs[v].P, vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].dt);
            repeat (2*vecs[v].len) tick();
            hs0 = 0; ls0 = 0; hs1 = 0; hs2 = 0;
            for (int c = 0; c < vecs[v].len; c++) begin
                tick();
                hs0 += int'(Pwm_Hs[0]); ls0 += int'(Pwm_Ls[0]);
                hs1 += int'(Pwm_Hs[1]); hs2 += int'(Pwm_Hs[2]);
            end
            chk($sformatf("v%0d_hs0", v), 32'(hs0), 32'(vecs[v].hs0));
            chk($sformatf("v%0d_ls0", v), 32'(ls0), 32'(vecs[v].ls0));
            chk($sformatf("v%0d_hs1", v), 32'(hs1), 32'(vecs[v].hs1));
            chk($sformatf("v%0d_hs2", v), 32'(hs2), 32'(vecs[v].hs2));
        end

        // Mid-period update: old duty holds until the boundary, then Ack and new duty.
        apply_cfg(0, 10, 3, 0, 20, 0);
        repeat (4) tick();
        set_shadow(0, 10, 7, 0, 20, 0);
        Update_Req = 1;
        tick();
        Update_Req = 0;
        w = 0; hs_between = 0;
        while (!Update_Ack && w < 20) begin
            hs_between += int'(Pwm_Hs[0]);
            tick();
            w++;
        end
        chk("upd_wait", 32'(w), 32'd5);
        chk("upd_hs_before", 32'(hs_between), 32'd0);
        hs0 = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c == 0) chk("upd_ack_pulse", 32'(Update_Ack), 32'd0);
            hs0 += int'(Pwm_Hs[0]);
        end
        chk("upd_hs_after", 32'(hs0), 32'd7);

        // Clear held every cycle: set wins at each boundary, one cycle per period.
        Irq_Clear = 1; irq_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            irq_cnt += int'(Irq_Status);
        end
        Irq_Clear = 0;
        chk("irq_set_wins", 32'(irq_cnt), 32'd3);

        // Enable low mid-period.
        repeat (3) tick();
        Enable = 0;
        tick();
        chk("dis_hs", 32'(Pwm_Hs), 32'd0);
        chk("dis_ls", 32'(Pwm_Ls), 32'd0);
        repeat (3) tick();
        Enable = 1;
        repeat (25) tick();

        // Reset mid-period.
        repeat (4) tick();
        Reset_n = 0;
        tick();
        chk("mid_rst_hs", 32'(Pwm_Hs), 32'd0);
        chk("mid_rst_ls", 32'(Pwm_Ls), 32'd0);
        chk("mid_rst_irq", 32'(Irq_Status), 32'd0);
        Reset_n = 1;

        // Randomized run against the model.
        for (int c = 0; c < 4000; c++) begin
            Update_Req = 0;
            if ($urandom_range(0, 19) == 0) begin
                set_shadow(1'($urandom_range(0, 1)), int'($urandom_range(0, 12)),
                           int'($urandom_range(0, 14)), int'($urandom_range(0, 14)),
                           int'($urandom_range(0, 14)), int'($urandom_range(0, 6)));
                Update_Req = 1;
            end
            if ($urandom_range(0, 49) == 0) Center_Mode = ~Center_Mode;
            Enable     = ($urandom_range(0, 99) != 0);
            Irq_Enable = ($urandom_range(0, 3) != 0);
            Irq_Clear  = ($urandom_range(0, 7) == 0);
            Reset_n    = ($urandom_range(0, 999) != 0);
            tick();
        end
        Update_Req = 0; Reset_n = 1;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
